// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversampling ratio
// and the elaboration-time baud accumulator increment.
package uart_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // round(baud * oversample * 2^acc_width / clk_freq), kept in 64 bits to avoid overflow
    function automatic longint calc_baud_inc(input longint clk_freq, input longint baud,
                                             input longint oversample, input int acc_width);
        return (baud * oversample * (longint'(1) << acc_width) + clk_freq / 2) / clk_freq;
    endfunction

endpackage

// File: rtl/uart_async_rx_if.sv
// Receiver-side bundle: serial input plus the received-byte outputs.
interface uart_async_rx_if;
    logic       RxD;
    logic       RxD_data_ready;
    logic       RxD_waiting_data;
    logic [7:0] RxD_data;

    modport master (input RxD, output RxD_data_ready, RxD_waiting_data, RxD_data);
    modport slave  (output RxD, input RxD_data_ready, RxD_waiting_data, RxD_data);
endinterface

// File: rtl/uart_baud_tick_gen.sv
// Fractional baud tick generator: free-running phase accumulator whose carry-out
// is the oversample tick. Usable by both receiver and transmitter.
module uart_baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int ACC_WIDTH  = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    // One bit wider than the accumulator so an increment of exactly 2^ACC_WIDTH is representable
    localparam logic [ACC_WIDTH:0] INC =
        (ACC_WIDTH + 1)'(calc_baud_inc(CLK_FREQ, BAUD, OVERSAMPLE, ACC_WIDTH));

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + INC;
        acc_d = sum[ACC_WIDTH-1:0];
    end

    assign tick = sum[ACC_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end
endmodule

// File: rtl/uart_async_rx.sv
// 8N1 UART receiver with 16x-style oversampling. Optional 2-of-3 majority voting
// per data/stop bit is enabled by defining UART_RX_MAJORITY_VOTE_EN.
module uart_async_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int ACC_WIDTH  = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_async_rx_if.master rx
);
    localparam int CW   = $clog2(OVERSAMPLE);
    localparam int HALF = OVERSAMPLE / 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] DECIDE_CNT = CW'(HALF + 1);
`else
    localparam logic [CW-1:0] DECIDE_CNT = CW'(HALF - 1);
`endif

    logic       tick;
    logic [1:0] sync_q;
    logic       rxd_s;
    logic       bit_val;
    rx_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bidx_q, bidx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       ready_q, ready_d;
    logic       waiting_q, waiting_d;

    uart_baud_tick_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign rxd_s = sync_q[1];

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] vote_q, vote_d;
    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_s) | (vote_q[1] & rxd_s);

    always_comb begin
        vote_d = vote_q;
        if (tick && (state_q == DATA || state_q == STOP)) begin
            if (cnt_q == CW'(HALF - 1)) vote_d[0] = rxd_s;
            if (cnt_q == CW'(HALF))     vote_d[1] = rxd_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) vote_q <= 2'b11;
        else     vote_q <= vote_d;
    end
`else
    assign bit_val = rxd_s;
`endif

    // cnt is re-phased at mid start bit so that in DATA/STOP it counts position within
    // the bit: wrap at OVERSAMPLE-1 is the bit boundary, HALF-1 is mid-bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rxd_s) state_d = START;
                end
                START: begin
                    if (cnt_q == CW'(HALF - 1)) begin
                        if (!rxd_s) begin
                            state_d = DATA;
                            cnt_d   = CW'(HALF);
                            bidx_d  = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == DECIDE_CNT) begin
                        shift_d = {bit_val, shift_q[7:1]};
                        if (bidx_q == 3'd7) state_d = STOP;
                        else                bidx_d  = bidx_q + 3'd1;
                    end
                end
                STOP: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == DECIDE_CNT) begin
                        if (bit_val) begin
                            data_d  = shift_q;
                            ready_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: if (rxd_s) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
        waiting_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bidx_q    <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            ready_q   <= 1'b0;
            waiting_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx.RxD};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bidx_q    <= bidx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            waiting_q <= waiting_d;
        end
    end

    assign rx.RxD_data         = data_q;
    assign rx.RxD_data_ready   = ready_q;
    assign rx.RxD_waiting_data = waiting_q;
endmodule

// File: tb/tb_uart_async_rx.sv
// Directed bench for uart_async_rx: tick every clk, 16 clk per bit; expected bytes
// are queued when a frame is sent and popped when the receiver strobes.
module tb_uart_async_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] exp_q[$];
    logic prev_ready = 1'b0;

    uart_async_rx_if dut_if();

    uart_async_rx #(
        .CLK_FREQ  (1600000),
        .BAUD      (100000),
        .OVERSAMPLE(16),
        .ACC_WIDTH (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (dut_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest queued byte, and no two strobes touch
    always @(negedge clk) begin
        if (dut_if.RxD_data_ready === 1'b1) begin
            logic have_exp;
            have_exp = (exp_q.size() > 0);
            $display("[TB] strobe: byte %h", dut_if.RxD_data);
            n_tests++;
            assert (have_exp === 1'b1) else begin
                n_fail++;
                $error("FAIL unexpected_strobe observed=%h expected=no_strobe", dut_if.RxD_data);
            end
            if (have_exp) check("strobe_data", dut_if.RxD_data, exp_q.pop_front());
            n_tests++;
            assert (prev_ready !== 1'b1) else begin
                n_fail++;
                $error("FAIL strobe_width observed=2clk expected=1clk");
            end
        end
        prev_ready = dut_if.RxD_data_ready;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        dut_if.RxD = v;
        idle(16);
    endtask

    // rst_bit >= 0 pulses reset in the middle of that data bit
    task automatic send(input logic [7:0] b, input logic stop, input int rst_bit);
        $display("[TB] send byte %h stop=%b rst_bit=%0d", b, stop, rst_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                dut_if.RxD = b[i];
                idle(4);
                rst = 1'b1;
                idle(2);
                rst = 1'b0;
                check("abort_data", dut_if.RxD_data, 8'h00);
                check("abort_ready", {7'd0, dut_if.RxD_data_ready}, 8'h00);
                idle(10);
            end else begin
                drive_bit(b[i]);
            end
            if (i == 3 && rst_bit < 0)
                check("midframe_waiting", {7'd0, dut_if.RxD_waiting_data}, 8'h00);
        end
        drive_bit(stop);
    endtask

    task automatic expect_drained(input string tag);
        idle(20);
        check(tag, 8'(exp_q.size()), 8'd0);
    endtask

    initial begin
        dut_if.RxD = 1'b1;
        // 1: reset held, line idle
        repeat (3) begin
            @(negedge clk);
            check("reset_data", dut_if.RxD_data, 8'h00);
            check("reset_ready", {7'd0, dut_if.RxD_data_ready}, 8'h00);
            check("reset_waiting", {7'd0, dut_if.RxD_waiting_data}, 8'h01);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            idle(1);
            check("idle_waiting", {7'd0, dut_if.RxD_waiting_data}, 8'h01);
        end

        // 2: single byte
        exp_q.push_back(8'hDF);
        send(8'hDF, 1'b1, -1);
        expect_drained("drain_DF");
        check("hold_DF", dut_if.RxD_data, 8'hDF);
        check("waiting_after_DF", {7'd0, dut_if.RxD_waiting_data}, 8'h01);

        // 3: back-to-back frames
        exp_q.push_back(8'h55);
        send(8'h55, 1'b1, -1);
        exp_q.push_back(8'hA3);
        send(8'hA3, 1'b1, -1);
        expect_drained("drain_55_A3");
        check("hold_A3", dut_if.RxD_data, 8'hA3);

        // 4: short start glitch
        $display("[TB] glitch 4 clk low");
        dut_if.RxD = 1'b0;
        idle(4);
        dut_if.RxD = 1'b1;
        idle(30);
        check("glitch_data", dut_if.RxD_data, 8'hA3);
        check("glitch_waiting", {7'd0, dut_if.RxD_waiting_data}, 8'h01);

        // 5: framing error then recovery
        send(8'h3C, 1'b0, -1);
        dut_if.RxD = 1'b1;
        idle(20);
        check("ferr_data", dut_if.RxD_data, 8'hA3);
        check("ferr_waiting", {7'd0, dut_if.RxD_waiting_data}, 8'h01);
        exp_q.push_back(8'h81);
        send(8'h81, 1'b1, -1);
        expect_drained("drain_81");
        check("hold_81", dut_if.RxD_data, 8'h81);

        // 6: reset mid-frame, then normal frame
        send(8'hFF, 1'b1, 4);
        idle(20);
        check("after_abort_data", dut_if.RxD_data, 8'h00);
        exp_q.push_back(8'h12);
        send(8'h12, 1'b1, -1);
        expect_drained("drain_12");
        check("hold_12", dut_if.RxD_data, 8'h12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
